alu_input_stage: RTL and testbench



---
 rtl/alu_input_stage.sv | 131 +++++++++++++
 tb/tb_alu_input_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_input_stage.sv
// alu_input_stage: synchronise the active-low ALU switches and EXEC button, debounce EXEC, and capture operands on each clean press.
// Defining ALU_IN_AUTOREPEAT_EN re-captures the operands every REPEAT_MAX clocks while EXEC stays held.
module alu_input_stage #(
    parameter int DEB_MAX    = 15,
    parameter int CNT_W      = 8,
    parameter int REPEAT_MAX = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode_n,
    input  logic [3:0] a_n,
    input  logic [3:0] b_n,
    input  logic       exec_n,
    output logic [3:0] opcode,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       load,
    output logic       busy,
    output logic [3:0] press_count
);
    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_MAX);
`ifdef ALU_IN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_MAX - 1);
`endif

    // The counter is shared by debounce and auto-repeat, so it must hold both limits.
    if ((2 ** CNT_W) - 1 < DEB_MAX || (2 ** CNT_W) - 1 < REPEAT_MAX) begin : g_cnt_w_check
        $error("alu_input_stage: CNT_W too small for DEB_MAX/REPEAT_MAX");
    end

    state_t           state_q, state_d;
    logic [12:0]      sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d, a_q, a_d, b_q, b_d, pc_q, pc_d;
    logic             load_q, busy_q;
    logic             ex, capture;
    logic [3:0]       sw_op, sw_a, sw_b;

    assign ex = sync2_q[12];
    assign {sw_op, sw_a, sw_b} = ~sync2_q[11:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ex) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (ex) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    capture = 1'b1;
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (ex) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
`ifdef ALU_IN_AUTOREPEAT_EN
                else if (cnt_q == REP_LAST) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RELEASE: begin
                if (!ex) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign op_d = capture ? sw_op : op_q;
    assign a_d  = capture ? sw_a : a_q;
    assign b_d  = capture ? sw_b : b_q;
    assign pc_d = pc_q + {3'b000, capture};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pc_q    <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= {exec_n, opcode_n, a_n, b_n};
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pc_q    <= pc_d;
            load_q  <= capture;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign opcode      = op_q;
    assign a           = a_q;
    assign b           = b_q;
    assign load        = load_q;
    assign busy        = busy_q;
    assign press_count = pc_q;
endmodule

// File: tb/tb_alu_input_stage.sv
// tb_alu_input_stage: randomized and directed checks of alu_input_stage against a run-length model of the debounced button.
// The model reasons about consecutive low/high samples of the synchronised button rather than FSM states.
module tb_alu_input_stage;
    localparam int DEB_MAX    = 3;
    localparam int REPEAT_MAX = 10;
`ifdef ALU_IN_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode_n = '0, a_n = '0, b_n = '0;
    logic       exec_n = 1'b0;
    logic [3:0] opcode, a, b, press_count;
    logic       load, busy;

    int asserts = 0;
    int fails = 0;

    logic [3:0]  m_op, m_a, m_b, m_pc;
    logic        m_load, m_busy;
    logic [12:0] dly[$];
    bit          armed;
    int          low_run, high_run, anchor, cyc;
    logic [17:0] dut_vec, mdl_vec;

    assign dut_vec = {opcode, a, b, load, busy, press_count};
    assign mdl_vec = {m_op, m_a, m_b, m_load, m_busy, m_pc};

    alu_input_stage #(.DEB_MAX(DEB_MAX), .CNT_W(8), .REPEAT_MAX(REPEAT_MAX)) dut (
        .clk(clk), .rst(rst), .opcode_n(opcode_n), .a_n(a_n), .b_n(b_n), .exec_n(exec_n),
        .opcode(opcode), .a(a), .b(b), .load(load), .busy(busy), .press_count(press_count)
    );

    always #5 clk = ~clk;

    // Advance one clock and update the model; inputs are only changed between calls (at the falling edge).
    task automatic tick();
        logic [12:0] s;
        bit cap, was_high;
        @(posedge clk);
        cyc++;
        m_load = 1'b0;
        if (rst) begin
            dly = '{13'h1fff, 13'h1fff};
            {m_op, m_a, m_b, m_pc, m_busy} = '0;
            armed = 1'b1;
            low_run = 0;
            high_run = 0;
            anchor = 0;
        end else begin
            s = dly.pop_front();
            dly.push_back({exec_n, opcode_n, a_n, b_n});
            cap = 1'b0;
            if (s[12]) begin
                high_run++;
                low_run = 0;
                if (!armed && high_run == DEB_MAX + 2) armed = 1'b1;
            end else begin
                was_high = high_run > 0;
                low_run++;
                high_run = 0;
                if (armed && low_run == DEB_MAX + 2) begin
                    cap = 1'b1;
                    armed = 1'b0;
                    anchor = cyc;
                end else if (!armed && AUTO) begin
                    if (was_high) anchor = cyc;
                    else if (cyc - anchor == REPEAT_MAX) begin
                        cap = 1'b1;
                        anchor = cyc;
                    end
                end
            end
            if (cap) begin
                {m_op, m_a, m_b} = ~s[11:0];
                m_load = 1'b1;
                m_pc = m_pc + 4'd1;
            end
            m_busy = !armed || low_run > 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {exec_n, opcode_n, a_n, b_n} = '0;
        repeat (2) tick();
        asserts++;
        if (dut_vec !== 18'h0) begin fails++; $display("FAIL reset_state: got %h want 0", dut_vec); end
        rst = 1'b0;
        {exec_n, opcode_n, a_n, b_n} = '1;
        repeat (8) begin
            tick();
            asserts++;
            if (dut_vec !== 18'h0) begin fails++; $display("FAIL reset_release cyc%0d: got %h want 0", cyc, dut_vec); end
        end
    endtask

    task automatic test_clean_press();
        int loads, load_at, idle_at;
        loads = 0; load_at = 0; idle_at = 0;
        opcode_n = 4'b1010; a_n = 4'b1100; b_n = 4'b0110; exec_n = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (load) begin loads++; load_at = k; end
            asserts++;
            if (dut_vec !== mdl_vec) begin fails++; $display("FAIL clean_press cyc%0d: got %h want %h", cyc, dut_vec, mdl_vec); end
        end
        asserts++;
        if (loads !== 1 || load_at !== 7) begin fails++; $display("FAIL clean_load_timing: loads=%0d at=%0d want 1 at 7", loads, load_at); end
        asserts++;
        if ({opcode, a, b, press_count, busy} !== {4'h5, 4'h3, 4'h9, 4'd1, 1'b1})
            begin fails++; $display("FAIL clean_capture: got %h%h%h pc=%0d busy=%b want 539 pc=1 busy=1", opcode, a, b, press_count, busy); end
        exec_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (!busy && idle_at == 0) idle_at = k;
            asserts++;
            if (dut_vec !== mdl_vec) begin fails++; $display("FAIL clean_release cyc%0d: got %h want %h", cyc, dut_vec, mdl_vec); end
        end
        asserts++;
        if (idle_at !== 7) begin fails++; $display("FAIL release_timing: idle after %0d want 7", idle_at); end
    endtask

    task automatic test_bounce();
        logic [17:0] snap;
        logic        pat[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int          loads;
        snap = dut_vec;
        loads = 0;
        opcode_n = 4'($urandom); a_n = 4'($urandom); b_n = 4'($urandom);
        for (int k = 0; k < 20; k++) begin
            exec_n = (k < 8) ? pat[k] : 1'b1;
            tick();
            if (load) loads++;
            asserts++;
            if (dut_vec !== mdl_vec) begin fails++; $display("FAIL bounce cyc%0d: got %h want %h", cyc, dut_vec, mdl_vec); end
        end
        asserts++;
        if (loads !== 0 || dut_vec !== snap) begin fails++; $display("FAIL bounce_reject: loads=%0d got %h want %h", loads, dut_vec, snap); end
    endtask

    task automatic test_switch_isolation();
        logic [3:0] a_exp;
        int         n;
        n = 0;
        a_n = 4'b0101; exec_n = 1'b0;
        while (!load && n < 20) begin tick(); n++; end
        asserts++;
        if (!load) begin fails++; $display("FAIL iso_timeout: load=%b want 1 within 20 clocks", load); end
        a_exp = a;
        for (int k = 0; k < 17; k++) begin
            if (k == 5) exec_n = 1'b1;
            a_n = ~a_n;
            tick();
            asserts++;
            if (a !== a_exp || load !== 1'b0 || dut_vec !== mdl_vec)
                begin fails++; $display("FAIL switch_iso cyc%0d: a=%h load=%b want a=%h load=0 (model %h)", cyc, a, load, a_exp, mdl_vec); end
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1; exec_n = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            opcode_n = 4'($urandom_range(0, 14)); a_n = 4'($urandom); b_n = 4'($urandom);
            for (int k = 0; k < 16; k++) begin
                exec_n = (k < 8) ? 1'b0 : 1'b1;
                tick();
                asserts++;
                if (dut_vec !== mdl_vec) begin fails++; $display("FAIL wrap cyc%0d: got %h want %h", cyc, dut_vec, mdl_vec); end
            end
            asserts++;
            if (press_count !== 4'(i)) begin fails++; $display("FAIL wrap_count: got %0d want %0d", press_count, 4'(i)); end
        end
    endtask

    task automatic test_mid_reset();
        opcode_n = 4'h0; a_n = 4'h0; b_n = 4'h0; exec_n = 1'b0;
        repeat (5) tick();
        asserts++;
        if (busy !== 1'b1 || load !== 1'b0 || dut_vec !== mdl_vec)
            begin fails++; $display("FAIL mid_press_state: got %h want %h", dut_vec, mdl_vec); end
        rst = 1'b1; exec_n = 1'b1;
        tick();
        rst = 1'b0;
        asserts++;
        if (dut_vec !== 18'h0) begin fails++; $display("FAIL mid_reset: got %h want 0", dut_vec); end
        repeat (10) begin
            tick();
            asserts++;
            if (dut_vec !== 18'h0 || dut_vec !== mdl_vec) begin fails++; $display("FAIL post_reset cyc%0d: got %h want 0", cyc, dut_vec); end
        end
    endtask

    task automatic test_autorepeat();
        int n, extra, last, bad_gap;
        n = 0; extra = 0; last = 0; bad_gap = 0;
        opcode_n = 4'($urandom); a_n = 4'($urandom); b_n = 4'($urandom); exec_n = 1'b0;
        while (!load && n < 20) begin tick(); n++; end
        asserts++;
        if (!load) begin fails++; $display("FAIL repeat_timeout: load=%b want 1 within 20 clocks", load); end
        for (int k = 1; k <= 40; k++) begin
            opcode_n = 4'($urandom); a_n = 4'($urandom); b_n = 4'($urandom);
            tick();
            if (load) begin
                extra++;
                if (k - last != REPEAT_MAX) bad_gap++;
                last = k;
            end
            asserts++;
            if (dut_vec !== mdl_vec) begin fails++; $display("FAIL autorepeat cyc%0d: got %h want %h", cyc, dut_vec, mdl_vec); end
        end
        asserts++;
        if (extra !== (AUTO ? 4 : 0) || bad_gap !== 0)
            begin fails++; $display("FAIL repeat_count: extra=%0d bad_gaps=%0d want %0d and 0", extra, bad_gap, AUTO ? 4 : 0); end
        exec_n = 1'b1;
        repeat (12) begin
            tick();
            asserts++;
            if (dut_vec !== mdl_vec) begin fails++; $display("FAIL repeat_release cyc%0d: got %h want %h", cyc, dut_vec, mdl_vec); end
        end
    endtask

    task automatic test_random();
        int len;
        for (int seg = 0; seg < 120; seg++) begin
            exec_n = 1'($urandom);
            opcode_n = 4'($urandom); a_n = 4'($urandom); b_n = 4'($urandom);
            len = (seg % 10 == 0) ? $urandom_range(10, 30) : $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                rst = ($urandom_range(0, 299) == 0);
                if (k == len / 2) a_n = 4'($urandom);
                tick();
                asserts++;
                if (dut_vec !== mdl_vec) begin fails++; $display("FAIL random cyc%0d: got %h want %h", cyc, dut_vec, mdl_vec); end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        dly = '{13'h1fff, 13'h1fff};
        test_reset();
        test_clean_press();
        test_bounce();
        test_switch_isolation();
        test_wrap();
        test_mid_reset();
        test_autorepeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
